// File: rtl/reg_file_8x_pkg.sv
// Shared constants and helpers for the eight-entry register file.
package reg_file_8x_pkg;

  localparam int REG_COUNT = 8;
  localparam int SEL_W     = 3;

  localparam logic [2:0] CC_N     = 3'b100;
  localparam logic [2:0] CC_Z     = 3'b010;
  localparam logic [2:0] CC_P     = 3'b001;
  localparam logic [2:0] CC_RESET = CC_Z;

  function automatic logic [3:0] popcount8(input logic [REG_COUNT-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < REG_COUNT; i++) begin
      cnt = cnt + {3'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/reg_file_8x_nzp_gen.sv
// Sign/zero classifier: maps a signed bus value to a one-hot {N,Z,P} code.
module nzp_gen
  import reg_file_8x_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [2:0]       cc_o
);

  logic signed [WIDTH-1:0] data_s;

  assign data_s = data_i;

  always_comb begin
    cc_o = CC_P;
    if (data_s < 0) begin
      cc_o = CC_N;
    end else if (data_s == '0) begin
      cc_o = CC_Z;
    end
  end

endmodule

// File: rtl/reg_file_8x.sv
// Eight-entry register file with one-hot load, two combinational read ports,
// optional write-through bypass, N/Z/P condition codes and a sticky multi-hot flag.
module reg_file_8x
  import reg_file_8x_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_COUNT-1:0] ld_vec,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 ld_cc,
  input  logic [SEL_W-1:0]     sr1,
  input  logic [SEL_W-1:0]     sr2,
  output logic [WIDTH-1:0]     sr1_out,
  output logic [WIDTH-1:0]     sr2_out,
  output logic [2:0]           nzp,
  output logic [REG_COUNT-1:0] valid,
  input  logic                 clr_err,
  output logic                 err_multi
);

  logic [WIDTH-1:0]     regs_q [REG_COUNT];
  logic [REG_COUNT-1:0] valid_q, valid_d;
  logic [2:0]           nzp_q, nzp_d;
  logic                 err_q, err_d;
  logic [2:0]           cc_new;
  logic [3:0]           ld_cnt;
  logic                 one_hot, multi_hot;

  assign ld_cnt    = popcount8(ld_vec);
  assign one_hot   = (ld_cnt == 4'd1);
  assign multi_hot = (ld_cnt > 4'd1);

  nzp_gen #(.WIDTH(WIDTH)) u_nzp_gen (
    .data_i (wr_data),
    .cc_o   (cc_new)
  );

  always_comb begin
    valid_d = valid_q;
    nzp_d   = nzp_q;
    err_d   = err_q & ~clr_err;
    if (one_hot) begin
      valid_d = valid_q | ld_vec;
    end
    if (ld_cc) begin
      nzp_d = cc_new;
    end
    // A fresh multi-hot error outranks a simultaneous clear.
    if (multi_hot) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      valid_q <= '0;
      nzp_q   <= CC_RESET;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (one_hot && ld_vec[i]) begin
          regs_q[i] <= wr_data;
        end
      end
      valid_q <= valid_d;
      nzp_q   <= nzp_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    sr1_out = regs_q[sr1];
    sr2_out = regs_q[sr2];
    if ((BYPASS != 0) && one_hot) begin
      if (ld_vec[sr1]) sr1_out = wr_data;
      if (ld_vec[sr2]) sr2_out = wr_data;
    end
  end

  assign nzp       = nzp_q;
  assign valid     = valid_q;
  assign err_multi = err_q;

endmodule

// File: tb/tb_reg_file_8x.sv
// Directed bench for reg_file_8x: write-through and stored-read variants side by side.
module tb_reg_file_8x;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ld_vec;
  logic [15:0] wr_data;
  logic        ld_cc;
  logic [2:0]  sr1, sr2;
  logic        clr_err;

  logic [15:0] b_sr1, b_sr2, s_sr1, s_sr2;
  logic [2:0]  b_nzp, s_nzp;
  logic [7:0]  b_valid, s_valid;
  logic        b_err, s_err;

  int total = 0;
  int bad   = 0;

  reg_file_8x #(.WIDTH(16), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .ld_vec(ld_vec), .wr_data(wr_data), .ld_cc(ld_cc),
    .sr1(sr1), .sr2(sr2), .sr1_out(b_sr1), .sr2_out(b_sr2), .nzp(b_nzp),
    .valid(b_valid), .clr_err(clr_err), .err_multi(b_err)
  );

  reg_file_8x #(.WIDTH(16), .BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ld_vec(ld_vec), .wr_data(wr_data), .ld_cc(ld_cc),
    .sr1(sr1), .sr2(sr2), .sr1_out(s_sr1), .sr2_out(s_sr2), .nzp(s_nzp),
    .valid(s_valid), .clr_err(clr_err), .err_multi(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] expv;

    rst_n   = 1'b0;
    ld_vec  = 8'h00;
    wr_data = 16'h0000;
    ld_cc   = 1'b0;
    sr1     = 3'd0;
    sr2     = 3'd0;
    clr_err = 1'b0;
    #2;

    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i);
      sr2 = 3'(7 - i);
      #1;
      chk("rst_sr1", b_sr1, 16'h0000);
      chk("rst_sr2", b_sr2, 16'h0000);
    end
    chk("rst_nzp", {13'd0, b_nzp}, 16'h0002);
    chk("rst_valid", {8'd0, b_valid}, 16'h0000);
    chk("rst_err", {15'd0, b_err}, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // One-hot write of register 3, bypass vs. stored read
    ld_vec = 8'h08; wr_data = 16'hBEEF; sr1 = 3'd3; sr2 = 3'd3;
    #1;
    chk("byp_sr1", b_sr1, 16'hBEEF);
    chk("byp_sr2", b_sr2, 16'hBEEF);
    chk("nobyp_sr1_old", s_sr1, 16'h0000);
    tick();
    ld_vec = 8'h00;
    #1;
    chk("nobyp_sr1_new", s_sr1, 16'hBEEF);
    chk("byp_sr1_stored", b_sr1, 16'hBEEF);
    chk("valid_after_w3", {8'd0, b_valid}, 16'h0008);
    chk("valid0_after_w3", {8'd0, s_valid}, 16'h0008);

    // Multi-hot load: no write, no bypass, sticky error
    ld_vec = 8'h81; wr_data = 16'h1234; sr1 = 3'd0; sr2 = 3'd7;
    #1;
    chk("multi_nobyp_sr1", b_sr1, 16'h0000);
    chk("multi_nobyp_sr2", b_sr2, 16'h0000);
    tick();
    ld_vec = 8'h00;
    #1;
    chk("multi_r0", b_sr1, 16'h0000);
    chk("multi_r7", b_sr2, 16'h0000);
    chk("multi_err", {15'd0, b_err}, 16'h0001);
    chk("multi_valid", {8'd0, b_valid}, 16'h0008);
    tick();
    chk("err_sticky", {15'd0, b_err}, 16'h0001);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("err_cleared", {15'd0, b_err}, 16'h0000);
    clr_err = 1'b1; ld_vec = 8'h06; wr_data = 16'h5A5A; sr1 = 3'd1; sr2 = 3'd2;
    tick();
    clr_err = 1'b0; ld_vec = 8'h00;
    #1;
    chk("err_set_wins", {15'd0, b_err}, 16'h0001);
    chk("multi2_r1", s_sr1, 16'h0000);
    chk("multi2_r2", s_sr2, 16'h0000);
    chk("multi2_valid", {8'd0, s_valid}, 16'h0008);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Condition codes
    ld_cc = 1'b1; wr_data = 16'h8000;
    tick();
    chk("cc_neg", {13'd0, b_nzp}, 16'h0004);
    wr_data = 16'h0000;
    tick();
    chk("cc_zero", {13'd0, b_nzp}, 16'h0002);
    wr_data = 16'h0001;
    tick();
    chk("cc_pos", {13'd0, b_nzp}, 16'h0001);
    wr_data = 16'hFFFF; ld_vec = 8'h30;
    tick();
    chk("cc_multihot_neg", {13'd0, s_nzp}, 16'h0004);
    chk("cc_multihot_err", {15'd0, s_err}, 16'h0001);
    ld_cc = 1'b0; ld_vec = 8'h00; wr_data = 16'h0000;
    tick();
    chk("cc_hold", {13'd0, b_nzp}, 16'h0004);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Fill all registers, then sweep both ports in opposite directions
    for (int i = 0; i < 8; i++) begin
      ld_vec  = 8'h01 << i;
      wr_data = 16'(i * 16'h1111);
      tick();
    end
    ld_vec = 8'h00; wr_data = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i);
      sr2 = 3'(7 - i);
      #1;
      expv = 16'(i * 16'h1111);
      chk("sweep_sr1", s_sr1, expv);
      expv = 16'((7 - i) * 16'h1111);
      chk("sweep_sr2", s_sr2, expv);
    end
    chk("valid_full", {8'd0, b_valid}, 16'h00FF);

    // Asynchronous reset between edges, with a write held during reset
    tick();
    ld_vec = 8'h01; wr_data = 16'h5555; sr1 = 3'd3; sr2 = 3'd7;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_sr1", b_sr1, 16'h0000);
    chk("async_sr2", b_sr2, 16'h0000);
    chk("async_nzp", {13'd0, b_nzp}, 16'h0002);
    chk("async_valid", {8'd0, b_valid}, 16'h0000);
    chk("async_err", {15'd0, b_err}, 16'h0000);
    tick();
    sr1 = 3'd0;
    #1;
    chk("rst_write_ignored", s_sr1, 16'h0000);
    chk("rst_write_valid", {8'd0, s_valid}, 16'h0000);
    ld_vec = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_r0", s_sr1, 16'h0000);
    chk("post_rst_valid", {8'd0, b_valid}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
